// File: rtl/qspi_arbiter.sv
// qspi_arbiter: shares one QSPI controller between the instruction-fetch and
// data ports. Data wins ties unless fetch has waited STARVE_LIMIT data grants.
// Illegal data accesses are answered locally in ERR and never reach the
// controller. A fetch abandoned by instr_stop still completes on the bus, but
// its result is dropped.
//
// Handshakes: a requester holds req and payload until its ack pulses. The
// controller accepts ctrl_start in the cycle where ctrl_busy=0. That cycle is
// the owner's ack. ctrl_start and the ctrl_* fields are stable until then.
// ctrl_done is only honoured in WAIT.
module qspi_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_stop,
  output logic              instr_ack,
  output logic              instr_done,
  output logic [31:0]       instr_rdata,
  input  logic              data_req,
  input  logic              data_write,
  input  logic [1:0]        data_len,
  input  logic [ADDR_W:0]   data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ack,
  output logic              data_done,
  output logic              data_err,
  output logic [31:0]       data_rdata,
  output logic              ctrl_start,
  output logic [1:0]        ctrl_sel,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_write,
  output logic [1:0]        ctrl_len,
  output logic [31:0]       ctrl_wdata,
  input  logic              ctrl_busy,
  input  logic              ctrl_done,
  input  logic [31:0]       ctrl_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_e;

  state_e            state_q, state_d;
  logic              owner_instr_q, owner_instr_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              discard_q, discard_d;
  logic [1:0]        ctrl_sel_q, ctrl_sel_d;
  logic [ADDR_W-1:0] ctrl_addr_q, ctrl_addr_d;
  logic              ctrl_write_q, ctrl_write_d;
  logic [1:0]        ctrl_len_q, ctrl_len_d;
  logic [31:0]       ctrl_wdata_q, ctrl_wdata_d;
  logic              instr_done_q, instr_done_d;
  logic              data_done_q, data_done_d;
  logic [31:0]       instr_rdata_q, instr_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;

  logic       instr_elig;
  logic       starve_hit;
  logic       grant_instr;
  logic       grant_data;
  logic [1:0] data_region;
  logic       data_illegal;
  logic       accept;

  assign data_region  = data_addr[ADDR_W:ADDR_W-1];
  // Region 01 is unmapped. Flash (00) is read-only.
  assign data_illegal = (data_region == 2'b01) || ((data_region == 2'b00) && data_write);
  assign instr_elig   = instr_req && !instr_stop;
  assign starve_hit   = (starve_cnt_q == STARVE_MAX);
  assign accept       = (state_q == S_ISSUE) && !ctrl_busy;

  // Next-state, grant decision, field capture and completion bookkeeping
  always_comb begin
    state_d       = state_q;
    owner_instr_d = owner_instr_q;
    starve_cnt_d  = starve_cnt_q;
    discard_d     = discard_q;
    ctrl_sel_d    = ctrl_sel_q;
    ctrl_addr_d   = ctrl_addr_q;
    ctrl_write_d  = ctrl_write_q;
    ctrl_len_d    = ctrl_len_q;
    ctrl_wdata_d  = ctrl_wdata_q;
    instr_done_d  = 1'b0;
    data_done_d   = 1'b0;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    grant_instr   = 1'b0;
    grant_data    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        discard_d   = 1'b0;
        grant_instr = instr_elig && (!data_req || starve_hit);
        grant_data  = data_req && !grant_instr;

        if (!instr_req) begin
          starve_cnt_d = 4'd0;
        end else if (grant_data && !starve_hit) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (grant_instr) begin
          starve_cnt_d  = 4'd0;
          owner_instr_d = 1'b1;
          ctrl_sel_d    = 2'd0;
          ctrl_addr_d   = instr_addr;
          ctrl_write_d  = 1'b0;
          ctrl_len_d    = 2'd3;
          ctrl_wdata_d  = 32'd0;
          state_d       = S_ISSUE;
        end else if (grant_data) begin
          owner_instr_d = 1'b0;
          if (data_illegal) begin
            state_d = S_ERR;
          end else begin
            ctrl_sel_d   = data_region[0] ? 2'd2 : (data_region[1] ? 2'd1 : 2'd0);
            ctrl_addr_d  = data_addr[ADDR_W-1:0];
            ctrl_write_d = data_write;
            ctrl_len_d   = data_len;
            ctrl_wdata_d = data_wdata;
            state_d      = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // A stop before acceptance still lets the start complete, then drops the result.
        if (owner_instr_q && instr_stop) discard_d = 1'b1;
        if (!ctrl_busy) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (owner_instr_q && instr_stop) discard_d = 1'b1;
        if (ctrl_done) begin
          state_d = S_IDLE;
          if (owner_instr_q) begin
            if (!(discard_q || instr_stop)) begin
              instr_done_d  = 1'b1;
              instr_rdata_d = ctrl_rdata;
            end
          end else begin
            data_done_d  = 1'b1;
            data_rdata_d = ctrl_rdata;
          end
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_instr_q <= 1'b0;
      starve_cnt_q  <= 4'd0;
      discard_q     <= 1'b0;
      ctrl_sel_q    <= 2'd0;
      ctrl_addr_q   <= '0;
      ctrl_write_q  <= 1'b0;
      ctrl_len_q    <= 2'd0;
      ctrl_wdata_q  <= 32'd0;
      instr_done_q  <= 1'b0;
      data_done_q   <= 1'b0;
      instr_rdata_q <= 32'd0;
      data_rdata_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      owner_instr_q <= owner_instr_d;
      starve_cnt_q  <= starve_cnt_d;
      discard_q     <= discard_d;
      ctrl_sel_q    <= ctrl_sel_d;
      ctrl_addr_q   <= ctrl_addr_d;
      ctrl_write_q  <= ctrl_write_d;
      ctrl_len_q    <= ctrl_len_d;
      ctrl_wdata_q  <= ctrl_wdata_d;
      instr_done_q  <= instr_done_d;
      data_done_q   <= data_done_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign ctrl_start  = (state_q == S_ISSUE);
  assign ctrl_sel    = ctrl_sel_q;
  assign ctrl_addr   = ctrl_addr_q;
  assign ctrl_write  = ctrl_write_q;
  assign ctrl_len    = ctrl_len_q;
  assign ctrl_wdata  = ctrl_wdata_q;
  assign instr_ack   = accept && owner_instr_q;
  assign instr_done  = instr_done_q;
  assign instr_rdata = instr_rdata_q;
  assign data_ack    = (accept && !owner_instr_q) || (state_q == S_ERR);
  assign data_done   = data_done_q || (state_q == S_ERR);
  assign data_err    = (state_q == S_ERR);
  assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_qspi_arbiter.sv
// tb_qspi_arbiter: directed scenarios plus a randomized backlog run checked
// against a transaction-level model of the grant rule and completion data.
module tb_qspi_arbiter;

  localparam int ADDR_W       = 24;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_stop;
  logic              instr_ack;
  logic              instr_done;
  logic [31:0]       instr_rdata;
  logic              data_req;
  logic              data_write;
  logic [1:0]        data_len;
  logic [ADDR_W:0]   data_addr;
  logic [31:0]       data_wdata;
  logic              data_ack;
  logic              data_done;
  logic              data_err;
  logic [31:0]       data_rdata;
  logic              ctrl_start;
  logic [1:0]        ctrl_sel;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_write;
  logic [1:0]        ctrl_len;
  logic [31:0]       ctrl_wdata;
  logic              ctrl_busy;
  logic              ctrl_done;
  logic [31:0]       ctrl_rdata;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_irdata;
  logic [31:0] exp_drdata;

  qspi_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_stop(instr_stop),
    .instr_ack(instr_ack), .instr_done(instr_done), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_write(data_write), .data_len(data_len),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
    .data_done(data_done), .data_err(data_err), .data_rdata(data_rdata),
    .ctrl_start(ctrl_start), .ctrl_sel(ctrl_sel), .ctrl_addr(ctrl_addr),
    .ctrl_write(ctrl_write), .ctrl_len(ctrl_len), .ctrl_wdata(ctrl_wdata),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_ctrl_start"}, 32'(ctrl_start), 32'd0);
    check_eq({pfx, "_ctrl_sel"}, 32'(ctrl_sel), 32'd0);
    check_eq({pfx, "_ctrl_addr"}, 32'(ctrl_addr), 32'd0);
    check_eq({pfx, "_ctrl_write"}, 32'(ctrl_write), 32'd0);
    check_eq({pfx, "_ctrl_len"}, 32'(ctrl_len), 32'd0);
    check_eq({pfx, "_ctrl_wdata"}, ctrl_wdata, 32'd0);
    check_eq({pfx, "_instr_ack"}, 32'(instr_ack), 32'd0);
    check_eq({pfx, "_instr_done"}, 32'(instr_done), 32'd0);
    check_eq({pfx, "_instr_rdata"}, instr_rdata, 32'd0);
    check_eq({pfx, "_data_ack"}, 32'(data_ack), 32'd0);
    check_eq({pfx, "_data_done"}, 32'(data_done), 32'd0);
    check_eq({pfx, "_data_err"}, 32'(data_err), 32'd0);
    check_eq({pfx, "_data_rdata"}, data_rdata, 32'd0);
  endtask

  // Advance until ctrl_start (kind 1) or a rejected data access (kind 2).
  task automatic wait_event(output int kind, output int n);
    kind = 0;
    n    = 0;
    do begin
      @(negedge clk);
      n++;
      if (ctrl_start === 1'b1) kind = 1;
      else if (data_err === 1'b1) kind = 2;
    end while (kind == 0 && n < 10);
    check_eq("grant_seen", 32'(kind != 0), 32'd1);
  endtask

  // Called at the ERR cycle of a rejected data access.
  task automatic check_err();
    check_eq("err_ack", 32'(data_ack), 32'd1);
    check_eq("err_done", 32'(data_done), 32'd1);
    check_eq("err_flag", 32'(data_err), 32'd1);
    check_eq("err_no_start", 32'(ctrl_start), 32'd0);
    check_eq("err_no_iack", 32'(instr_ack), 32'd0);
    check_eq("err_drdata_hold", data_rdata, exp_drdata);
  endtask

  // Controller model: called at the first cycle ctrl_start is seen.
  task automatic serve_txn(input bit own_i, input logic [1:0] e_sel, input logic [ADDR_W-1:0] e_addr,
                           input logic e_wr, input logic [1:0] e_len, input logic [31:0] e_wd,
                           input int busy, input int lat, input logic [31:0] rd, input bit stop);
    for (int b = 0; b <= busy; b++) begin
      ctrl_busy = (b < busy);
      #1;
      check_eq("ctrl_start", 32'(ctrl_start), 32'd1);
      check_eq("ctrl_sel", 32'(ctrl_sel), 32'(e_sel));
      check_eq("ctrl_addr", 32'(ctrl_addr), 32'(e_addr));
      check_eq("ctrl_write", 32'(ctrl_write), 32'(e_wr));
      check_eq("ctrl_len", 32'(ctrl_len), 32'(e_len));
      if (!own_i) check_eq("ctrl_wdata", ctrl_wdata, e_wd);
      check_eq("instr_ack", 32'(instr_ack), 32'(own_i && b == busy));
      check_eq("data_ack", 32'(data_ack), 32'(!own_i && b == busy));
      @(negedge clk);
    end
    ctrl_busy = 1'b0;
    check_eq("start_drop", 32'(ctrl_start), 32'd0);
    for (int l = 0; l < lat; l++) begin
      instr_stop = stop && (l == 0);
      check_eq("early_idone", 32'(instr_done), 32'd0);
      check_eq("early_ddone", 32'(data_done), 32'd0);
      @(negedge clk);
    end
    instr_stop = 1'b0;
    ctrl_done  = 1'b1;
    ctrl_rdata = rd;
    @(negedge clk);
    ctrl_done  = 1'b0;
    ctrl_rdata = $urandom;
    if (own_i && !stop) exp_irdata = rd;
    if (!own_i) exp_drdata = rd;
    check_eq("instr_done", 32'(instr_done), 32'(own_i && !stop));
    check_eq("data_done", 32'(data_done), 32'(!own_i));
    check_eq("data_err", 32'(data_err), 32'd0);
    check_eq("instr_rdata", instr_rdata, exp_irdata);
    check_eq("data_rdata", data_rdata, exp_drdata);
  endtask

  task automatic drive_data(input logic wr, input logic [1:0] len, input logic [ADDR_W:0] addr,
                            input logic [31:0] wd);
    data_req   = 1'b1;
    data_write = wr;
    data_len   = len;
    data_addr  = addr;
    data_wdata = wd;
  endtask

  initial begin
    int          kind;
    int          n;
    int          starve;
    logic [1:0]  region;
    logic [1:0]  e_sel;
    bit          illegal;

    rst = 1'b1;
    instr_req = 1'b0; instr_addr = '0; instr_stop = 1'b0;
    data_req = 1'b0; data_write = 1'b0; data_len = 2'd0; data_addr = '0; data_wdata = 32'd0;
    ctrl_busy = 1'b0; ctrl_done = 1'b0; ctrl_rdata = 32'd0;
    exp_irdata = 32'd0;
    exp_drdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    // Fetch only
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 24'h000100;
    wait_event(kind, n);
    check_eq("t1_latency", 32'(n), 32'd1);
    serve_txn(1'b1, 2'd0, 24'h000100, 1'b0, 2'd3, 32'd0, 0, 2, 32'h12345678, 1'b0);
    instr_req = 1'b0;
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(instr_done), 32'd0);

    // Simultaneous requests: data first
    instr_req  = 1'b1;
    instr_addr = 24'h000200;
    drive_data(1'b0, 2'd3, 25'h1000010, 32'hA5A5A5A5);
    wait_event(kind, n);
    check_eq("t2_data_latency", 32'(n), 32'd1);
    serve_txn(1'b0, 2'd1, 24'h000010, 1'b0, 2'd3, 32'hA5A5A5A5, 3, 1, 32'hCAFEF00D, 1'b0);
    data_req = 1'b0;
    wait_event(kind, n);
    check_eq("t2_instr_latency", 32'(n), 32'd1);
    serve_txn(1'b1, 2'd0, 24'h000200, 1'b0, 2'd3, 32'd0, 0, 0, 32'h0BADC0DE, 1'b0);
    instr_req = 1'b0;
    @(negedge clk);

    // Rejected data accesses
    drive_data(1'b1, 2'd3, 25'h0000040, 32'h55AA55AA);
    wait_event(kind, n);
    check_eq("t4_kind_store", 32'(kind), 32'd2);
    check_eq("t4_latency_store", 32'(n), 32'd1);
    check_err();
    data_req = 1'b0;
    @(negedge clk);
    check_eq("t4_err_pulse", 32'(data_err), 32'd0);
    check_eq("t4_no_start", 32'(ctrl_start), 32'd0);
    drive_data(1'b0, 2'd1, 25'h0800000, 32'd0);
    wait_event(kind, n);
    check_eq("t4_kind_read", 32'(kind), 32'd2);
    check_eq("t4_latency_read", 32'(n), 32'd1);
    check_err();
    data_req = 1'b0;
    @(negedge clk);
    check_eq("t4_no_start2", 32'(ctrl_start), 32'd0);

    // Stop during WAIT discards; stop in IDLE blocks the grant
    instr_req  = 1'b1;
    instr_addr = 24'h000300;
    wait_event(kind, n);
    serve_txn(1'b1, 2'd0, 24'h000300, 1'b0, 2'd3, 32'd0, 1, 2, 32'hDEADBEEF, 1'b1);
    instr_addr = 24'h000400;
    instr_stop = 1'b1;
    @(negedge clk);
    check_eq("t5_stop_no_start", 32'(ctrl_start), 32'd0);
    check_eq("t5_stop_no_ack", 32'(instr_ack), 32'd0);
    instr_stop = 1'b0;
    wait_event(kind, n);
    check_eq("t5_refetch_latency", 32'(n), 32'd1);
    serve_txn(1'b1, 2'd0, 24'h000400, 1'b0, 2'd3, 32'd0, 0, 1, 32'h11223344, 1'b0);
    instr_req = 1'b0;
    @(negedge clk);

    // Reset in WAIT
    instr_req  = 1'b1;
    instr_addr = 24'h000500;
    wait_event(kind, n);
    ctrl_busy = 1'b0;
    #1;
    check_eq("t6_ack", 32'(instr_ack), 32'd1);
    @(negedge clk);
    instr_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("t6_reset");
    exp_irdata = 32'd0;
    exp_drdata = 32'd0;
    ctrl_done  = 1'b1;
    ctrl_rdata = 32'h77777777;
    @(negedge clk);
    ctrl_done = 1'b0;
    check_eq("t6_no_idone", 32'(instr_done), 32'd0);
    check_eq("t6_no_ddone", 32'(data_done), 32'd0);
    check_eq("t6_irdata", instr_rdata, 32'd0);

    // Randomized backlog: both ports always pending
    starve     = 0;
    instr_req  = 1'b1;
    instr_addr = 24'($urandom);
    drive_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 25'($urandom), $urandom);
    for (int t = 0; t < 48; t++) begin
      wait_event(kind, n);
      if (starve == STARVE_LIMIT) begin
        check_eq("rnd_kind_instr", 32'(kind), 32'd1);
        if (kind != 1) break;
        serve_txn(1'b1, 2'd0, instr_addr, 1'b0, 2'd3, 32'd0,
                  $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'b0);
        starve     = 0;
        instr_addr = 24'($urandom);
      end else begin
        starve++;
        region  = data_addr[ADDR_W:ADDR_W-1];
        illegal = (region == 2'b01) || (region == 2'b00 && data_write);
        e_sel   = (region == 2'b10) ? 2'd1 : ((region == 2'b11) ? 2'd2 : 2'd0);
        if (illegal) begin
          check_eq("rnd_kind_err", 32'(kind), 32'd2);
          if (kind != 2) break;
          check_err();
        end else begin
          check_eq("rnd_kind_data", 32'(kind), 32'd1);
          if (kind != 1) break;
          serve_txn(1'b0, e_sel, data_addr[ADDR_W-1:0], data_write, data_len, data_wdata,
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'b0);
        end
        drive_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 25'($urandom), $urandom);
      end
    end
    instr_req = 1'b0;
    data_req  = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
